// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
//   Direct-mapped, write-through, no-write-allocate data cache for the memory
//   stage. Each of the 2**INDEX_BITS lines holds one 32-bit word plus a tag and
//   a valid bit. Load hits return data combinationally. Load misses fill the
//   line from backing memory. Every store is written through to memory, and a
//   store that hits also updates the cached word. While a fill or write-through
//   is outstanding, StallM freezes the pipeline.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ReqM              memory-stage access valid this cycle
//   MemWriteM         1 = store, 0 = load
//   LdSrcM / StSrcM   1 = byte access, 0 = word access
//   ALUResultM        byte address
//   WriteDataM        store data (a byte store uses [7:0])
//   ReadDataM         load result (a byte load is zero-extended)
//   StallM            hold the pipeline up to and including EX/MEM
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb
//                     registered word request to backing memory
//   mem_rdata/mem_ack one-cycle completion pulse with read data
// -----------------------------------------------------------------------------
module data_cache #(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ReqM,
  input  logic                  MemWriteM,
  input  logic                  LdSrcM,
  input  logic                  StSrcM,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [31:0]           WriteDataM,
  output logic [31:0]           ReadDataM,
  output logic                  StallM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [31:0]           r_data [LINES];

  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic [3:0]            r_mem_wstrb;

  logic [INDEX_BITS-1:0] w_idx;
  logic [INDEX_BITS-1:0] w_txn_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [TAG_W-1:0]      w_txn_tag;
  logic [31:0]           w_line;
  logic [31:0]           w_load_data;
  logic [31:0]           w_merged;
  logic                  w_hit;
  logic                  w_txn_hit;
  logic                  w_issue;
  logic                  w_fill_done;
  logic                  w_write_done;

  // Lookup for the access currently presented by the pipeline.
  assign w_idx  = ALUResultM[INDEX_BITS+1:2];
  assign w_tag  = ALUResultM[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_line = r_data[w_idx];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // Completions are keyed off the latched request address, so they do not
  // depend on the pipeline still presenting the same access.
  assign w_txn_idx = r_mem_addr[INDEX_BITS+1:2];
  assign w_txn_tag = r_mem_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_txn_hit = r_valid[w_txn_idx] && (r_tag[w_txn_idx] == w_txn_tag);

  assign w_issue      = !rst && (r_state == IDLE) && ReqM && (MemWriteM || !w_hit);
  assign w_fill_done  = !rst && (r_state == FILL) && mem_ack;
  assign w_write_done = !rst && (r_state == WRITE) && mem_ack;

  // Little-endian byte select for byte loads.
  always_comb begin
    // NOTE: assigning a default first keeps every path assigned, so no latch is inferred.
    w_load_data = w_line;
    if (LdSrcM) begin
      case (ALUResultM[1:0])
        2'd0:    w_load_data = {24'b0, w_line[7:0]};
        2'd1:    w_load_data = {24'b0, w_line[15:8]};
        2'd2:    w_load_data = {24'b0, w_line[23:16]};
        default: w_load_data = {24'b0, w_line[31:24]};
      endcase
    end
  end

  // Store hit: the strobed lanes of the outgoing write replace the cached word.
  // The write data is already lane-aligned (byte stores are replicated).
  always_comb begin
    w_merged = r_data[w_txn_idx];
    for (int b = 0; b < 4; b++) begin
      if (r_mem_wstrb[b]) w_merged[8*b +: 8] = r_mem_wdata[8*b +: 8];
    end
  end

  // Next-state and pipeline-facing outputs.
  always_comb begin
    w_next_state = r_state;
    StallM       = 1'b0;
    ReadDataM    = 32'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (ReqM) begin
            if (MemWriteM) begin
              StallM       = 1'b1;
              w_next_state = WRITE;
            end else if (w_hit) begin
              ReadDataM = w_load_data;
            end else begin
              StallM       = 1'b1;
              w_next_state = FILL;
            end
          end
        end
        FILL: begin
          // The replayed load hits in the cycle after the fill.
          StallM = 1'b1;
          if (mem_ack) w_next_state = IDLE;
        end
        WRITE: begin
          // The pipeline advances on the ack cycle, so the store is not reissued.
          StallM = !mem_ack;
          if (mem_ack) w_next_state = IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Valid bits and the memory request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wstrb <= 4'b0;
    end else if (w_issue) begin
      r_mem_req  <= 1'b1;
      r_mem_we   <= MemWriteM;
      r_mem_addr <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
      if (!MemWriteM) begin
        r_mem_wstrb <= 4'b0000;
      end else if (StSrcM) begin
        r_mem_wstrb <= 4'b0001 << ALUResultM[1:0];
        r_mem_wdata <= {4{WriteDataM[7:0]}};
      end else begin
        r_mem_wstrb <= 4'b1111;
        r_mem_wdata <= WriteDataM;
      end
    end else if (w_fill_done || w_write_done) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wstrb <= 4'b0;
      if (w_fill_done) r_valid[w_txn_idx] <= 1'b1;
    end
  end

  // Tag and data arrays.
  // NOTE: the arrays have no reset; a cleared valid bit makes their contents don't-care.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag[w_txn_idx]  <= w_txn_tag;
      r_data[w_txn_idx] <= mem_rdata;
    end else if (w_write_done && w_txn_hit) begin
      r_data[w_txn_idx] <= w_merged;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_data_cache.sv
// -----------------------------------------------------------------------------
// tb_data_cache
//   Scoreboard bench for data_cache. A driver issues loads and stores, holding
//   each access until the cache stops stalling. For every access it predicts,
//   from a reference model, the memory transaction, the number of stall cycles
//   and the load result, and queues them. The reference model is a tag/valid
//   table plus a flat word memory. A monitor pops and compares these whenever
//   the DUT accepts an access or starts a memory request. A responder process
//   models backing memory with a programmable ack delay.
// -----------------------------------------------------------------------------
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ReqM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic        LdSrcM = 1'b0;
  logic        StSrcM = 1'b0;
  logic [31:0] ALUResultM = 32'b0;
  logic [31:0] WriteDataM = 32'b0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'b0;
  logic        mem_ack = 1'b0;

  data_cache #(.INDEX_BITS(4), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ReqM       (ReqM),
    .MemWriteM  (MemWriteM),
    .LdSrcM     (LdSrcM),
    .StSrcM     (StSrcM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // ---------------- scoreboard queues ----------------
  typedef struct {
    bit          is_load;
    logic [31:0] rdata;
    int          stalls;
  } acc_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  acc_t exp_acc[$];
  txn_t exp_txn[$];

  // ---------------- reference model ----------------
  bit          ref_valid [16];
  int          ref_tag   [16];
  logic [31:0] ref_mem   [int];
  logic [31:0] phys_mem  [int];

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] phys_rd(input int w);
    return phys_mem.exists(w) ? phys_mem[w] : init_word(w);
  endfunction

  // ---------------- backing-memory responder ----------------
  int resp_en   = 1;
  int ack_delay = 1;
  int stray_req = 0;

  initial begin
    int cnt = 0;
    int stray_done = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (stray_req != stray_done) begin
        stray_done++;
        mem_rdata = 32'hBAD0BAD0;
        mem_ack   = 1'b1;
      end else if (rst || !mem_req || resp_en == 0) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= ack_delay) begin
          int w;
          logic [31:0] word;
          w    = int'(mem_addr >> 2);
          word = phys_rd(w);
          mem_rdata = word;
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
            phys_mem[w] = word;
          end
          mem_ack = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int   stall_cnt = 0;
    bit   prev_req = 1'b0;
    txn_t cap;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
        prev_req  = 1'b0;
      end else begin
        if (ReqM) begin
          if (StallM) begin
            stall_cnt++;
          end else if (exp_acc.size() == 0) begin
            check("unexpected_accept", 32'd1, 32'd0);
          end else begin
            acc_t a;
            a = exp_acc.pop_front();
            check("stall_cycles", stall_cnt, a.stalls);
            if (a.is_load) check("load_data", ReadDataM, a.rdata);
            stall_cnt = 0;
          end
        end
        if (mem_req && !prev_req) begin
          cap = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
          if (exp_txn.size() == 0) begin
            check("unexpected_mem_req", mem_addr, 32'hFFFFFFFF);
          end else begin
            txn_t t;
            t = exp_txn.pop_front();
            check("mem_we", 32'(mem_we), 32'(t.we));
            check("mem_addr", mem_addr, t.addr);
            if (t.we) begin
              check("mem_wdata", mem_wdata, t.wdata);
              check("mem_wstrb", 32'(mem_wstrb), 32'(t.wstrb));
            end
          end
        end
        if (mem_req && mem_ack) begin
          check("hold_addr", mem_addr, cap.addr);
          check("hold_ctl", {27'b0, mem_we, mem_wstrb}, {27'b0, cap.we, cap.wstrb});
          if (cap.we) check("hold_wdata", mem_wdata, cap.wdata);
        end
        prev_req = mem_req;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic access(input bit we, input bit byte_op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int delay);
    int          w;
    int          idx;
    int          tag;
    int          lane;
    bit          hit;
    bit          accepted;
    logic [31:0] word;
    logic [31:0] wd;
    logic [3:0]  strb;
    w    = int'(addr / 4);
    idx  = w % 16;
    tag  = int'(addr / 64);
    lane = int'(addr % 4);
    hit  = ref_valid[idx] && (ref_tag[idx] == tag);
    if (!we) begin
      word = ref_rd(w);
      if (!hit) begin
        exp_txn.push_back('{we: 1'b0, addr: 32'(w * 4), wdata: 32'b0, wstrb: 4'b0});
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tag;
      end
      exp_acc.push_back('{is_load: 1'b1,
                          rdata: byte_op ? ((word >> (8 * lane)) & 32'hFF) : word,
                          stalls: hit ? 0 : delay + 1});
    end else begin
      strb = byte_op ? 4'(1 << lane) : 4'hF;
      wd   = byte_op ? {4{wdata[7:0]}} : wdata;
      exp_txn.push_back('{we: 1'b1, addr: 32'(w * 4), wdata: wd, wstrb: strb});
      exp_acc.push_back('{is_load: 1'b0, rdata: 32'b0, stalls: delay});
      word = ref_rd(w);
      for (int b = 0; b < 4; b++)
        if (strb[b]) word[8*b +: 8] = wd[8*b +: 8];
      ref_mem[w] = word;
    end
    ack_delay  = delay;
    ReqM       = 1'b1;
    MemWriteM  = we;
    LdSrcM     = byte_op && !we;
    StSrcM     = byte_op && we;
    ALUResultM = addr;
    WriteDataM = wdata;
    accepted   = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      accepted = !StallM;
      @(posedge clk);
      #1;
      if (accepted) break;
    end
    ReqM = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: addr %08h still stalled after 60 cycles", addr);
      finish_sim();
    end
  endtask

  // Abandon a fill with reset, then send a stray ack.
  task automatic reset_mid_fill();
    resp_en = 0;
    exp_txn.push_back('{we: 1'b0, addr: 32'h344, wdata: 32'b0, wstrb: 4'b0});
    ReqM       = 1'b1;
    MemWriteM  = 1'b0;
    LdSrcM     = 1'b0;
    StSrcM     = 1'b0;
    ALUResultM = 32'h344;
    repeat (3) @(posedge clk);
    #1;
    rst  = 1'b1;
    ReqM = 1'b0;
    @(negedge clk);
    check("rst_fill_stall", 32'(StallM), 32'd0);
    check("rst_fill_rdata", ReadDataM, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    stray_req++;
    repeat (3) begin
      @(negedge clk);
      check("mem_req_after_rst", 32'(mem_req), 32'd0);
    end
    @(posedge clk);
    #1;
    resp_en = 1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    phys_mem[32'h40] = 32'hDEADBEEF;
    ref_mem[32'h40]  = 32'hDEADBEEF;
    for (int i = 0; i < 16; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = 0;
    end

    // Reset with a load presented: outputs must stay quiet.
    ReqM       = 1'b1;
    ALUResultM = 32'h100;
    repeat (3) begin
      @(negedge clk);
      check("reset_stall", 32'(StallM), 32'd0);
      check("reset_rdata", ReadDataM, 32'd0);
    end
    @(posedge clk);
    #1;
    rst  = 1'b0;
    ReqM = 1'b0;
    @(negedge clk);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_mem_wstrb", 32'(mem_wstrb), 32'd0);
    @(posedge clk);
    #1;

    // Directed scenarios.
    access(1'b0, 1'b0, 32'h100, 32'h0, 3);         // miss, 4 stall cycles
    access(1'b0, 1'b0, 32'h100, 32'h0, 1);         // hit
    access(1'b1, 1'b1, 32'h102, 32'h55, 2);        // byte store hit
    access(1'b0, 1'b1, 32'h102, 32'h0, 1);         // lbu -> 0x55
    access(1'b0, 1'b0, 32'h100, 32'h0, 1);         // lw -> 0xDE55BEEF
    access(1'b0, 1'b0, 32'h140, 32'h0, 2);         // conflicting tag
    access(1'b0, 1'b0, 32'h100, 32'h0, 1);         // evicted, misses again
    access(1'b1, 1'b0, 32'h200, 32'h12345678, 1);  // store miss, immediate ack
    access(1'b0, 1'b0, 32'h200, 32'h0, 2);         // no allocate: misses
    access(1'b0, 1'b0, 32'h100, 32'h0, 1);         // refill 0x100
    reset_mid_fill();
    access(1'b0, 1'b0, 32'h100, 32'h0, 2);         // valids cleared: misses

    // Randomized traffic over four tags so lines conflict often.
    repeat (300) begin
      logic [31:0] a;
      bit          we;
      bit          bo;
      a  = 32'($urandom_range(0, 255));
      we = ($urandom_range(0, 2) == 0);
      bo = $urandom_range(0, 1) == 1;
      access(we, bo, a, $urandom, int'($urandom_range(1, 4)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    check("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
    check("txn_queue_drained", 32'(exp_txn.size()), 32'd0);
    finish_sim();
  end

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_sim();
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Acts as the responder to the memory stage. It serves loads and stores issued with ALUResultM / WriteDataM / MemWriteM / LdSrcM / StSrcM.
- Issues word transactions to backing memory over a req/ack handshake.
- Freezes the pipeline through StallM while a miss fill or a store write-through is outstanding.

Parameters:
- INDEX_BITS, 4, log2 of line count (16 lines, one 32-bit word per line).
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ReqM  in  1  memory-stage access valid this cycle
- MemWriteM  in  1  1 = store, 0 = load
- LdSrcM  in  1  1 = byte load (zero-extended), 0 = word load
- StSrcM  in  1  1 = byte store, 0 = word store
- ALUResultM  in  ADDR_WIDTH  byte address
- WriteDataM  in  32  store data (byte store uses [7:0])
- ReadDataM  out  32  load result
- StallM  out  1  hold all pipeline registers upstream of and including EX/MEM
- mem_req  out  1  backing-memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_WIDTH  word-aligned address ([1:0] = 00)
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte-lane write strobes
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse

Behaviour:
Address fields:
- index = ALUResultM[INDEX_BITS+1:2]
- tag = ALUResultM[ADDR_WIDTH-1:INDEX_BITS+2]
- Word accesses ignore ALUResultM[1:0].

Storage:
- Per line: valid bit, tag, 32-bit data.
- Little-endian byte lanes.

FSM states: IDLE, FILL, WRITE.

Reset:
- state = IDLE; all valid bits cleared; mem_req = 0; mem_we = 0; mem_wstrb = 0.
- Combinational outputs during reset: StallM = 0, ReadDataM = 0.

IDLE:
- Load hit (ReqM & !MemWriteM & valid & tag match):
  - ReadDataM driven combinationally the same cycle.
  - Word load: line data. Byte load: {24'b0, selected byte}.
  - StallM = 0; no memory traffic.
- Load miss: StallM = 1 combinationally; next state FILL. Registered mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}.
- Store (hit or miss): StallM = 1; next state WRITE. Registered mem_req=1, mem_we=1.
  - Word store: mem_wstrb=1111, mem_wdata=WriteDataM.
  - Byte store: mem_wstrb=0001<<addr[1:0], mem_wdata=byte replicated to all four lanes.
- Otherwise: ReadDataM = 0, StallM = 0.

FILL:
- StallM = 1; mem_req held.
- On mem_ack: line gets valid=1, tag, data=mem_rdata; mem_req drops at the edge; next state IDLE.
- The replayed load then hits in the following cycle.
- Load-miss latency = ack cycle + 1.

WRITE:
- StallM = !mem_ack; mem_req held.
- On mem_ack: if the line hits, merge the strobed bytes into line data; mem_req drops; next state IDLE. The pipeline advances on the ack cycle, so the store is not reissued.
- A store miss does not allocate.

Handshake:
- mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb are registered and held stable from assertion until the ack cycle inclusive.
- mem_ack is legal from the first mem_req cycle onward. mem_ack while mem_req=0 is ignored.

Input stability:
- Pipeline inputs are held stable while StallM=1. A transaction in FILL/WRITE completes regardless of ReqM.

Reset mid-operation:
- Rst in FILL/WRITE abandons the transaction: mem_req=0 next cycle, no line written, valids cleared.
- A late mem_ack after reset is ignored.

Conflict:
- Addresses differing only in tag evict each other.

Test Plan:
- Reset, lw 0x100, memory acks 0xDEADBEEF on the 3rd mem_req cycle -> StallM high 4 cycles, mem_addr=0x100, mem_we=0; next cycle ReadDataM=0xDEADBEEF, StallM=0.
- lw 0x100 again -> hit: ReadDataM=0xDEADBEEF same cycle, mem_req stays 0.
- sb 0x55 to 0x102 -> mem_we=1, mem_wstrb=0100, mem_wdata=0x55555555, StallM low on ack cycle; then lbu 0x102 returns 0x00000055 and lw 0x100 returns 0xDE55BEEF, both hits.
- lw 0x140 (same index, different tag) -> miss fill; then lw 0x100 -> miss again (eviction).
- sw 0x12345678 to 0x200 (not cached), immediate ack -> StallM for 1 cycle, mem_wstrb=1111; subsequent lw 0x200 misses (no allocate).
- Assert rst during FILL -> mem_req=0 next cycle, a later stray mem_ack ignored, lw 0x100 afterwards misses.
